trap_sequencer: RTL and testbench

//  Sequences pipeline control when the CSR/exception unit raises a trap or an MRET commits.

---
 rtl/trap_sequencer.sv | 111 +++++++++++
 tb/tb_trap_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Trap/MRET pipeline sequencer: flush, drain outstanding memory traffic,
// redirect the PC to mtvec or mepc, then hold fetch while the pipe refills.
module trap_sequencer #(
  parameter int DRAIN_TIMEOUT = 15,
  parameter int REFILL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        initiate_exception,
  input  logic        mret,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  input  logic        mem_busy,
  output logic        flush,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        mret_commit,
  output logic        busy,
  output logic        timeout_err,
  output logic [15:0] trap_count
);

  localparam int CW = $clog2(DRAIN_TIMEOUT + 1);
  localparam int RW = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;
  localparam logic [CW-1:0] DRAIN_LAST  = CW'(DRAIN_TIMEOUT - 1);
  localparam logic [RW-1:0] REFILL_LAST = RW'(REFILL_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT, REFILL} state_t;

  typedef struct packed {
    logic        is_mret;
    logic [31:0] pc;
  } target_t;

  state_t          state;
  target_t         target;
  logic [CW-1:0]   drain_cnt;
  logic [RW-1:0]   refill_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      target         <= '0;
      drain_cnt      <= '0;
      refill_cnt     <= '0;
      flush          <= 1'b0;
      stall          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      mret_commit    <= 1'b0;
      busy           <= 1'b0;
      timeout_err    <= 1'b0;
      trap_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          flush          <= 1'b0;
          stall          <= 1'b0;
          redirect_valid <= 1'b0;
          mret_commit    <= 1'b0;
          busy           <= 1'b0;
          // A trap wins; a coincident mret belongs to a killed instruction.
          if (initiate_exception) begin
            target.is_mret <= 1'b0;
            target.pc      <= {csr_mtvec[31:2], 2'b00};
            if (trap_count != 16'hFFFF) trap_count <= trap_count + 16'd1;
          end else if (mret) begin
            target.is_mret <= 1'b1;
            target.pc      <= {csr_mepc[31:2], 2'b00};
          end
          if (initiate_exception || mret) begin
            drain_cnt <= '0;
            state     <= DRAIN;
            flush     <= 1'b1;
            stall     <= 1'b1;
            busy      <= 1'b1;
          end
        end
        DRAIN: begin
          flush <= 1'b0;
          if (drain_cnt != {CW{1'b1}}) drain_cnt <= drain_cnt + CW'(1);
          if (!mem_busy || drain_cnt == DRAIN_LAST) begin
            state          <= REDIRECT;
            redirect_valid <= 1'b1;
            redirect_pc    <= target.pc;
            mret_commit    <= target.is_mret;
            if (mem_busy) timeout_err <= 1'b1;
          end
        end
        REDIRECT: begin
          redirect_valid <= 1'b0;
          mret_commit    <= 1'b0;
          refill_cnt     <= '0;
          state          <= REFILL;
        end
        REFILL: begin
          if (refill_cnt == REFILL_LAST) begin
            state <= IDLE;
            stall <= 1'b0;
            busy  <= 1'b0;
          end else begin
            refill_cnt <= refill_cnt + RW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: stimulus pushes expected redirects,
// a negedge monitor pops and compares each redirect strobe.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        initiate_exception;
  logic        mret;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic        mem_busy;
  logic        flush;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mret_commit;
  logic        busy;
  logic        timeout_err;
  logic [15:0] trap_count;

  trap_sequencer #(.DRAIN_TIMEOUT(15), .REFILL_CYCLES(1)) dut (
    .clk(clk), .reset(reset),
    .initiate_exception(initiate_exception), .mret(mret),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .mem_busy(mem_busy),
    .flush(flush), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mret_commit(mret_commit), .busy(busy),
    .timeout_err(timeout_err), .trap_count(trap_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc;
    logic        mret;
    logic [15:0] cnt;
    logic        terr;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_tot  = 0;
  logic prev_rv = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic m, input logic [15:0] c,
                          input logic t, input int dly);
    exp_t e;
    e.pc = pc; e.mret = m; e.cnt = c; e.terr = t; e.cyc = cyc + dly;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, {26'd0, flush, stall, redirect_valid, mret_commit, busy, timeout_err}, 32'd0);
    chk({tag, "_count"}, {16'd0, trap_count}, 32'd0);
    chk({tag, "_pc"}, redirect_pc, 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk({tag, "_idle_bound"}, {31'd0, busy}, 32'd0);
  endtask

  // Monitor: every redirect strobe must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (prev_rv) chk("strobe_one_cycle", {30'd0, redirect_valid, mret_commit}, 32'd0);
    prev_rv = redirect_valid;
    if (redirect_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_redirect", redirect_pc, 32'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        chk("redirect_pc", redirect_pc, e.pc);
        chk("mret_commit", {31'd0, mret_commit}, {31'd0, e.mret});
        chk("trap_count", {16'd0, trap_count}, {16'd0, e.cnt});
        chk("timeout_err", {31'd0, timeout_err}, {31'd0, e.terr});
        chk("redirect_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; initiate_exception = 1'b0; mret = 1'b0;
    csr_mtvec = '0; csr_mepc = '0; mem_busy = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Trap with no memory traffic: minimum latency.
    csr_mtvec = 32'h0000_0104; initiate_exception = 1'b1;
    push_exp(32'h104, 1'b0, 16'd1, 1'b0, 2);
    @(negedge clk); initiate_exception = 1'b0;
    chk("t1_flush_c1", {31'd0, flush}, 32'd1);
    chk("t1_stall_c1", {31'd0, stall}, 32'd1);
    @(negedge clk); chk("t1_flush_c2", {31'd0, flush}, 32'd0);
    @(negedge clk); chk("t1_stall_c3", {31'd0, stall}, 32'd1);
    @(negedge clk);
    chk("t1_busy_c4", {31'd0, busy}, 32'd0);
    chk("t1_stall_c4", {31'd0, stall}, 32'd0);

    // Drain wait: mem_busy high c1..c3, low from c4.
    csr_mtvec = 32'h0000_0200; initiate_exception = 1'b1; mem_busy = 1'b1;
    push_exp(32'h200, 1'b0, 16'd2, 1'b0, 5);
    @(negedge clk); initiate_exception = 1'b0;
    repeat (3) @(negedge clk);
    mem_busy = 1'b0;
    wait_idle("t2");
    chk("t2_no_timeout", {31'd0, timeout_err}, 32'd0);

    // Drain timeout with mem_busy stuck high.
    csr_mtvec = 32'h0000_0300; initiate_exception = 1'b1; mem_busy = 1'b1;
    push_exp(32'h300, 1'b0, 16'd3, 1'b1, 16);
    @(negedge clk); initiate_exception = 1'b0;
    repeat (15) @(negedge clk);
    mem_busy = 1'b0;
    wait_idle("t3");
    chk("t3_timeout_sticky", {31'd0, timeout_err}, 32'd1);

    // Trap and mret together: trap wins.
    csr_mtvec = 32'h0000_0104; csr_mepc = 32'h0000_0080;
    initiate_exception = 1'b1; mret = 1'b1;
    push_exp(32'h104, 1'b0, 16'd4, 1'b1, 2);
    @(negedge clk); initiate_exception = 1'b0; mret = 1'b0;
    wait_idle("t4");

    // MRET alone, low bits of mepc masked.
    csr_mepc = 32'h0000_0083; mret = 1'b1;
    push_exp(32'h080, 1'b1, 16'd4, 1'b1, 2);
    @(negedge clk); mret = 1'b0;
    wait_idle("t5");
    chk("t5_count_unchanged", {16'd0, trap_count}, 32'd4);
    chk("t5_pc_hold", redirect_pc, 32'h80);

    // Reset while draining aborts with no redirect.
    csr_mtvec = 32'h0000_0400; initiate_exception = 1'b1; mem_busy = 1'b1;
    @(negedge clk); initiate_exception = 1'b0;
    chk("t6_busy_drain", {31'd0, busy}, 32'd1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check_zero("t6_reset");
    reset = 1'b0; mem_busy = 1'b0;
    repeat (6) @(negedge clk);
    chk("t6_stays_idle", {31'd0, busy}, 32'd0);

    // Saturation: preload near the top, then three back-to-back traps
    // from a held request level.
    force dut.trap_count = 16'hFFFE;
    @(negedge clk);
    release dut.trap_count;
    csr_mtvec = 32'h0000_0500; initiate_exception = 1'b1;
    push_exp(32'h500, 1'b0, 16'hFFFF, 1'b0, 2);
    push_exp(32'h500, 1'b0, 16'hFFFF, 1'b0, 6);
    push_exp(32'h500, 1'b0, 16'hFFFF, 1'b0, 10);
    repeat (9) @(negedge clk);
    initiate_exception = 1'b0;
    wait_idle("t7");
    chk("t7_saturated", {16'd0, trap_count}, 32'h0000_FFFF);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
